// File: rtl/puf_ctrl_pkg.sv
// Shared register map, CTRL bit positions and sequencer states for the PUF Wishbone controller.
package puf_ctrl_pkg;
    localparam int OFF_CTRL   = 0;
    localparam int OFF_CHAL   = 1;
    localparam int OFF_STATUS = 2;
    localparam int OFF_ID0    = 3;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_START  = 1;
    localparam int CTRL_BUSY   = 2;
    localparam int CTRL_DONE   = 3;
    localparam int CTRL_IRQ_EN = 4;

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, RESOLVE} state_t;

    localparam logic [31:0] DEFAULT_READ_VALUE = 32'hBADFABAC;
endpackage

// File: rtl/puf_vote_accum.sv
// Per-bit majority vote over repeated PUF samples, plus a count of bits whose samples disagreed.
// Latency: the vote result and unstable count register on the edge where resolve is high.
// Backpressure: none; the sequencer paces it through the clr, sample and resolve strobes.
module puf_vote_accum
    import puf_ctrl_pkg::*;
#(
    parameter int ID_WIDTH     = 96,
    parameter int VOTE_SAMPLES = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr,
    input  logic                sample,
    input  logic                resolve,
    input  logic [ID_WIDTH-1:0] raw,
    output logic [ID_WIDTH-1:0] id,
    output logic [7:0]          unstable
);
    localparam int CW = $clog2(VOTE_SAMPLES + 1);
    localparam logic [CW-1:0] FULL = CW'(VOTE_SAMPLES);
    localparam logic [CW-1:0] HALF = CW'(VOTE_SAMPLES / 2);

    logic [CW-1:0]       cnt [ID_WIDTH];
    logic [ID_WIDTH-1:0] maj;
    logic [7:0]          pop_sat;
    int                  pop;

    // A bit is unstable when its ones-count is neither zero nor every sample.
    always_comb begin
        maj = '0;
        pop = 0;
        for (int i = 0; i < ID_WIDTH; i++) begin
            maj[i] = (cnt[i] > HALF);
            if (cnt[i] != '0 && cnt[i] != FULL) pop = pop + 1;
        end
        pop_sat = (pop > 255) ? 8'hFF : 8'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ID_WIDTH; i++) cnt[i] <= '0;
            id       <= '0;
            unstable <= '0;
        end else begin
            if (clr) begin
                for (int i = 0; i < ID_WIDTH; i++) cnt[i] <= '0;
            end else if (sample) begin
                for (int i = 0; i < ID_WIDTH; i++) cnt[i] <= cnt[i] + CW'(raw[i]);
            end
            if (resolve) begin
                id       <= maj;
                unstable <= pop_sat;
            end
        end
    end
endmodule

// File: rtl/puf_wb_ctrl.sv
// Wishbone slave that sequences arbiter-PUF evaluations: enable, settle, vote over samples, store ID.
// Latency: ack/err one edge after an in-window strobe; ID valid SETTLE_CYCLES+VOTE_SAMPLES+1 edges after START.
// Backpressure: never stalls; a held strobe is answered on every other cycle.
module puf_wb_ctrl
    import puf_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'hF0001800,
    parameter int          ADDR_WIDTH    = 11,
    parameter int          CHAL_WIDTH    = 32,
    parameter int          ID_WIDTH      = 96,
    parameter int          SETTLE_CYCLES = 16,
    parameter int          VOTE_SAMPLES  = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    input  logic                  wb_we_i,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_cyc_i,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  puf_en_o,
    output logic [CHAL_WIDTH-1:0] puf_challenge_o,
    input  logic [ID_WIDTH-1:0]   puf_id_i,
    output logic                  irq_o
);
    localparam int ID_WORDS = (ID_WIDTH + 31) / 32;
    localparam int OW       = ADDR_WIDTH - 2;
    localparam int TMAX     = (SETTLE_CYCLES > VOTE_SAMPLES) ? SETTLE_CYCLES : VOTE_SAMPLES;
    localparam int TW       = $clog2(TMAX + 1);

    state_t                  state_q, state_d;
    logic [TW-1:0]           tmr_q, tmr_d;
    logic                    en_q, irq_en_q, done_q, done_d, en_d;
    logic [CHAL_WIDTH-1:0]   chal_q;
    logic [31:0]             chal_m, rdata;
    logic [OW-1:0]           off;
    logic                    hit, req, valid_off, ctrl_wr, chal_wr, start, abort, busy;
    logic                    clr, smp, res;
    logic [ID_WIDTH-1:0]     id_q;
    logic [ID_WORDS*32-1:0]  id_pad;
    logic [7:0]              unstable;
    logic                    unused_adr;

    assign unused_adr = ^wb_adr_i[1:0];
    assign hit        = (wb_adr_i[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);
    assign req        = wb_cyc_i & wb_stb_i & hit & ~wb_ack_o & ~wb_err_o;
    assign off        = wb_adr_i[ADDR_WIDTH-1:2];
    assign valid_off  = (int'(off) < OFF_ID0 + ID_WORDS);
    assign ctrl_wr    = req & wb_we_i & (off == OW'(OFF_CTRL)) & wb_sel_i[0];
    assign chal_wr    = req & wb_we_i & (off == OW'(OFF_CHAL));
    assign busy       = (state_q != IDLE);
    assign puf_en_o   = (state_q == SETTLE) | (state_q == SAMPLE);

    // EN as it will be after this edge, so a clearing write aborts right away.
    assign en_d  = ctrl_wr ? wb_dat_i[CTRL_EN] : en_q;
    assign start = ctrl_wr & wb_dat_i[CTRL_START] & wb_dat_i[CTRL_EN] & ~busy;
    assign abort = busy & ~en_d;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        clr     = 1'b0;
        smp     = 1'b0;
        res     = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = SETTLE;
                tmr_d   = TW'(SETTLE_CYCLES - 1);
                clr     = 1'b1;
            end
            SETTLE: if (tmr_q == '0) begin
                state_d = SAMPLE;
                tmr_d   = TW'(VOTE_SAMPLES - 1);
            end else begin
                tmr_d = tmr_q - TW'(1);
            end
            SAMPLE: begin
                smp = 1'b1;
                if (tmr_q == '0) state_d = RESOLVE;
                else             tmr_d   = tmr_q - TW'(1);
            end
            RESOLVE: begin
                res     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            smp     = 1'b0;
            res     = 1'b0;
        end
        // Completion is applied last so it beats a DONE clear on the same edge.
        done_d = done_q;
        if (ctrl_wr && wb_dat_i[CTRL_DONE]) done_d = 1'b0;
        if (start) done_d = 1'b0;
        if (res)   done_d = 1'b1;
    end

    always_comb begin
        chal_m = 32'(chal_q);
        for (int b = 0; b < 4; b++) begin
            if (wb_sel_i[b]) chal_m[8*b +: 8] = wb_dat_i[8*b +: 8];
        end
    end

    always_comb begin
        id_pad                 = '0;
        id_pad[ID_WIDTH-1:0]   = id_q;
    end

    always_comb begin
        rdata = DEFAULT_READ_VALUE;
        if (off == OW'(OFF_CTRL)) begin
            rdata = 32'({irq_en_q, done_q, busy, 1'b0, en_q});
        end else if (off == OW'(OFF_CHAL)) begin
            rdata = 32'(chal_q);
        end else if (off == OW'(OFF_STATUS)) begin
            rdata = {8'h00, 8'(ID_WIDTH), 8'(VOTE_SAMPLES), unstable};
        end else begin
            for (int k = 0; k < ID_WORDS; k++) begin
                if (int'(off) == OFF_ID0 + k) rdata = id_pad[32*k +: 32];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            tmr_q           <= '0;
            en_q            <= 1'b0;
            irq_en_q        <= 1'b0;
            done_q          <= 1'b0;
            chal_q          <= '0;
            puf_challenge_o <= '0;
            wb_ack_o        <= 1'b0;
            wb_err_o        <= 1'b0;
            wb_dat_o        <= '0;
            irq_o           <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            done_q   <= done_d;
            irq_o    <= done_q & irq_en_q;
            wb_ack_o <= req & valid_off;
            wb_err_o <= req & ~valid_off;
            if (req) wb_dat_o <= rdata;
            if (ctrl_wr) begin
                en_q     <= wb_dat_i[CTRL_EN];
                irq_en_q <= wb_dat_i[CTRL_IRQ_EN];
            end
            if (chal_wr) chal_q <= chal_m[CHAL_WIDTH-1:0];
            if (start)   puf_challenge_o <= chal_q;
        end
    end

    puf_vote_accum #(
        .ID_WIDTH     (ID_WIDTH),
        .VOTE_SAMPLES (VOTE_SAMPLES)
    ) u_vote (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr      (clr),
        .sample   (smp),
        .resolve  (res),
        .raw      (puf_id_i),
        .id       (id_q),
        .unstable (unstable)
    );
endmodule

// File: tb/tb_puf_wb_ctrl.sv
// Self-checking bench for puf_wb_ctrl: register-access table, directed timing sequences, randomized votes.
module tb_puf_wb_ctrl;
    localparam int S   = 16;
    localparam int V   = 5;
    localparam int IDW = 96;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
    logic        wb_we_i = 1'b0, wb_stb_i = 1'b0, wb_cyc_i = 1'b0;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_ack_o, wb_err_o, puf_en_o, irq_o;
    logic [31:0] puf_challenge_o;
    logic [IDW-1:0] puf_id_i;

    always #5 clk_i = ~clk_i;

    puf_wb_ctrl #(
        .BASE_ADDR(32'hF0001800), .ADDR_WIDTH(11), .CHAL_WIDTH(32),
        .ID_WIDTH(IDW), .SETTLE_CYCLES(S), .VOTE_SAMPLES(V)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i),
        .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .puf_en_o(puf_en_o),
        .puf_challenge_o(puf_challenge_o), .puf_id_i(puf_id_i), .irq_o(irq_o)
    );

    int n_pass = 0, n_tot = 0;
    int cyc_n = 0;
    always @(posedge clk_i) cyc_n = cyc_n + 1;

    // Observers: enable-cycle total, last enable rise and last irq rise (edge index).
    int   en_total = 0, en_rise = -1, irq_rise = -1;
    logic en_prev = 1'b0, irq_prev = 1'b0;
    always @(negedge clk_i) begin
        if (puf_en_o) en_total = en_total + 1;
        if (puf_en_o && !en_prev) en_rise = cyc_n;
        if (irq_o && !irq_prev) irq_rise = cyc_n;
        en_prev  = puf_en_o;
        irq_prev = irq_o;
    end

    // PUF model: the j-th sampling cycle after settling sees samp[j]; everything else is noise.
    logic [IDW-1:0] samp [V];
    logic [IDW-1:0] const_id;
    logic           drive_on = 1'b0;
    int             start_cyc = 1 << 30;
    always @(negedge clk_i) begin
        int j;
        j = cyc_n - start_cyc - S;
        if (!drive_on)            puf_id_i = const_id;
        else if (j >= 0 && j < V) puf_id_i = samp[j];
        else                      puf_id_i = {$urandom, $urandom, $urandom};
    end

    task automatic model(output logic [IDW-1:0] eid, output logic [7:0] euns);
        int n;
        n = 0;
        for (int i = 0; i < IDW; i++) begin
            int ones;
            ones = 0;
            for (int s = 0; s < V; s++) ones = ones + int'(samp[s][i]);
            eid[i] = (ones > V / 2);
            if (ones != 0 && ones != V) n = n + 1;
        end
        euns = (n > 255) ? 8'hFF : 8'(n);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot = n_tot + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    function automatic logic [31:0] adr(input int off);
        return 32'hF0001800 | (32'(off) << 2);
    endfunction

    int   last_ack_cyc = 0;
    logic last_irq = 1'b0;

    // Caller sits 1ns after an edge. resp = {lat[3:0], 2'b0, err, ack}.
    task automatic bus(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] sel, output logic [31:0] rd, output logic [31:0] resp);
        int   lat;
        logic ack, err;
        wb_adr_i = a; wb_dat_i = d; wb_we_i = we; wb_sel_i = sel;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        lat = 0; ack = 1'b0; err = 1'b0;
        while (!ack && !err && lat < 8) begin
            @(posedge clk_i); #1;
            lat = lat + 1;
            ack = wb_ack_o;
            err = wb_err_o;
        end
        rd = wb_dat_o;
        last_ack_cyc = cyc_n;
        last_irq = irq_o;
        resp = {24'b0, lat[3:0], 2'b00, err, ack};
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic wreg(input string nm, input int off, input logic [31:0] d);
        logic [31:0] rd, resp;
        bus(1'b1, adr(off), d, 4'hF, rd, resp);
        check({nm, "_wack"}, resp, 32'h11);
    endtask

    task automatic rreg(input string nm, input int off, input logic [31:0] exp);
        logic [31:0] rd, resp;
        bus(1'b0, adr(off), 32'h0, 4'hF, rd, resp);
        check({nm, "_rack"}, resp, 32'h11);
        check(nm, rd, exp);
    endtask

    task automatic wait_until(input int c);
        while (cyc_n < c) begin
            @(posedge clk_i); #1;
        end
    endtask

    typedef struct {
        logic        we;
        int          off;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic [31:0] exp_rd;
        logic [31:0] exp_resp;
    } vec_t;
    vec_t tbl [18];

    initial begin
        logic [31:0]    rd, resp, c1, c2;
        logic [IDW-1:0] base, eid;
        logic [7:0]     euns;
        int             t, en0, acks;

        const_id = {32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF};
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ack_err_en_irq", {28'b0, wb_ack_o, wb_err_o, puf_en_o, irq_o}, 32'h0);
        check("rst_dat", wb_dat_o, 32'h0);
        check("rst_chal_out", puf_challenge_o, 32'h0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        tbl[0]  = '{1'b0, 0, 32'h0,        4'hF, 32'h00000000, 32'h11};
        tbl[1]  = '{1'b0, 2, 32'h0,        4'hF, 32'h00600500, 32'h11};
        tbl[2]  = '{1'b0, 3, 32'h0,        4'hF, 32'h00000000, 32'h11};
        tbl[3]  = '{1'b0, 1, 32'h0,        4'hF, 32'h00000000, 32'h11};
        tbl[4]  = '{1'b1, 1, 32'hA5A51234, 4'hF, 32'h0,        32'h11};
        tbl[5]  = '{1'b0, 1, 32'h0,        4'hF, 32'hA5A51234, 32'h11};
        tbl[6]  = '{1'b1, 1, 32'hFFFFFFFF, 4'h2, 32'h0,        32'h11};
        tbl[7]  = '{1'b0, 1, 32'h0,        4'hF, 32'hA5A5FF34, 32'h11};
        tbl[8]  = '{1'b1, 1, 32'hA5A51234, 4'hF, 32'h0,        32'h11};
        tbl[9]  = '{1'b0, 6, 32'h0,        4'hF, 32'hBADFABAC, 32'h12};
        tbl[10] = '{1'b1, 7, 32'hFFFFFFFF, 4'hF, 32'h0,        32'h12};
        tbl[11] = '{1'b0, 1, 32'h0,        4'hF, 32'hA5A51234, 32'h11};
        tbl[12] = '{1'b0, 0, 32'h0,        4'hF, 32'h00000000, 32'h11};
        tbl[13] = '{1'b1, 2, 32'hFFFFFFFF, 4'hF, 32'h0,        32'h11};
        tbl[14] = '{1'b0, 2, 32'h0,        4'hF, 32'h00600500, 32'h11};
        tbl[15] = '{1'b1, 0, 32'h00000013, 4'hE, 32'h0,        32'h11};
        tbl[16] = '{1'b0, 0, 32'h0,        4'hF, 32'h00000000, 32'h11};
        tbl[17] = '{1'b0, 5, 32'h0,        4'hF, 32'h00000000, 32'h11};
        for (int i = 0; i < 18; i++) begin
            bus(tbl[i].we, adr(tbl[i].off), tbl[i].wdat, tbl[i].sel, rd, resp);
            check($sformatf("tbl%0d_resp", i), resp, tbl[i].exp_resp);
            if (!tbl[i].we) check($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
        end
        check("no_start_from_bad_lane", {31'b0, puf_en_o}, 32'h0);

        bus(1'b0, 32'hF0000800, 32'h0, 4'hF, rd, resp);
        check("outside_window", resp, 32'h80);
        bus(1'b1, 32'h00001800, 32'h13, 4'hF, rd, resp);
        check("outside_alias", resp, 32'h80);

        wb_adr_i = adr(0); wb_we_i = 1'b0; wb_sel_i = 4'hF; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        acks = 0;
        repeat (6) begin
            @(posedge clk_i); #1;
            acks = acks + int'(wb_ack_o) + 16 * int'(wb_err_o);
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(posedge clk_i); #1;
        check("held_strobe_acks", 32'(acks), 32'd3);

        // Constant response, IRQ enabled: enable span, DONE/irq timing, ID words.
        en0 = en_total;
        wreg("ctrl_start_irq", 0, 32'h13);
        t = last_ack_cyc;
        check("chal_out_copied", puf_challenge_o, 32'hA5A51234);
        wait_until(t + 30);
        check("en_cycles", 32'(en_total - en0), 32'd21);
        check("en_rise_offset", 32'(en_rise - t), 32'd0);
        check("irq_rise_offset", 32'(irq_rise - t), 32'd23);
        rreg("ctrl_done_irq", 0, 32'h19);
        rreg("id0_const", 3, 32'hDEADBEEF);
        rreg("id1_const", 4, 32'h89ABCDEF);
        rreg("id2_const", 5, 32'h01234567);
        rreg("status_const", 2, 32'h00600500);
        wreg("ctrl_done_w1c", 0, 32'h18);
        check("irq_high_at_clear", {31'b0, last_irq}, 32'h1);
        check("irq_dropped", {31'b0, irq_o}, 32'h0);

        // DONE edge: clear+start together, then read just before and just after completion.
        wreg("ctrl_clr_start", 0, 32'h0B);
        t = last_ack_cyc;
        wait_until(t + 21);
        rreg("ctrl_in_resolve", 0, 32'h05);
        rreg("ctrl_after_done", 0, 32'h09);

        // Bit 0 high in 2 of 5 samples, bit 1 high in 3 of 5.
        base = {32'h0, 32'hFFFF0000, 32'hDEADBEEC};
        for (int s = 0; s < V; s++) begin
            samp[s] = base;
            if (s == 0 || s == 3) samp[s][0] = 1'b1;
            if (s == 1 || s == 2 || s == 4) samp[s][1] = 1'b1;
        end
        model(eid, euns);
        drive_on = 1'b1;
        wreg("ctrl_start_flip", 0, 32'h03);
        start_cyc = last_ack_cyc;
        wait_until(start_cyc + 25);
        rreg("id0_flip", 3, 32'hDEADBEEE);
        rreg("id1_flip", 4, eid[63:32]);
        rreg("status_flip", 2, 32'h00600502);

        // Abort by clearing EN in the second sampling cycle.
        for (int s = 0; s < V; s++) samp[s] = {$urandom, $urandom, $urandom};
        en0 = en_total;
        wreg("ctrl_start_abort", 0, 32'h03);
        t = last_ack_cyc;
        start_cyc = t;
        wait_until(t + 17);
        wreg("ctrl_abort", 0, 32'h00);
        wait_until(t + 35);
        check("abort_en_cycles", 32'(en_total - en0), 32'd18);
        rreg("ctrl_after_abort", 0, 32'h00);
        rreg("id0_after_abort", 3, 32'hDEADBEEE);
        rreg("status_after_abort", 2, 32'h00600502);

        en0 = en_total;
        wreg("ctrl_start_no_en", 0, 32'h02);
        wait_until(cyc_n + 25);
        check("no_en_no_eval", 32'(en_total - en0), 32'd0);
        rreg("ctrl_no_en", 0, 32'h00);

        // Randomized votes, with a challenge rewrite and a stray START while busy.
        for (int it = 0; it < 6; it++) begin
            c1 = $urandom;
            wreg("rnd_chal1", 1, c1);
            base = {$urandom, $urandom, $urandom};
            for (int s = 0; s < V; s++)
                samp[s] = base ^ ({$urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom}
                                  & {$urandom, $urandom, $urandom});
            model(eid, euns);
            wreg("rnd_start", 0, 32'h03);
            start_cyc = last_ack_cyc;
            check("rnd_chal_out", puf_challenge_o, c1);
            c2 = $urandom;
            wreg("rnd_chal2", 1, c2);
            check("rnd_chal_hold", puf_challenge_o, c1);
            wreg("rnd_start_busy", 0, 32'h03);
            wait_until(start_cyc + 25);
            rreg("rnd_ctrl", 0, 32'h09);
            rreg("rnd_id0", 3, eid[31:0]);
            rreg("rnd_id1", 4, eid[63:32]);
            rreg("rnd_id2", 5, eid[95:64]);
            rreg("rnd_status", 2, {16'h0060, 8'h05, euns});
            rreg("rnd_chal_reg", 1, c2);
        end

        // Reset in the middle of an evaluation.
        wreg("ctrl_start_rst", 0, 32'h13);
        wait_until(cyc_n + 5);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check("rst_mid_en", {31'b0, puf_en_o}, 32'h0);
        check("rst_mid_chal_out", puf_challenge_o, 32'h0);
        rreg("rst_mid_ctrl", 0, 32'h00);
        rreg("rst_mid_id0", 3, 32'h00000000);
        rreg("rst_mid_status", 2, 32'h00600500);
        rreg("rst_mid_chal", 1, 32'h00000000);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/puf_wb_ctrl.md
# puf_wb_ctrl

Second-generation Wishbone slave for the arbiter-PUF path. It sits between the NEORV32 external bus and one `puf` instance, and adds a configurable-width challenge and ID. Each evaluation is sequenced: the PUF is enabled, allowed to settle, then sampled several times. A majority vote over those samples produces the stored ID, plus a count of unstable bits. Completion is signalled by a status flag and an optional interrupt.

## Interface
Parameters:
- `BASE_ADDR`, 32'hF0001800: base of the register window.
- `ADDR_WIDTH`, 11: window size in address bits; hit when `wb_adr_i[31:ADDR_WIDTH]` matches `BASE_ADDR[31:ADDR_WIDTH]`.
- `CHAL_WIDTH`, 32: challenge width, 1..32.
- `ID_WIDTH`, 96: PUF response width, 1..255. `ID_WORDS` = ceil(`ID_WIDTH`/32).
- `SETTLE_CYCLES`, 16: cycles between enable and first sample, ≥1.
- `VOTE_SAMPLES`, 5: samples per evaluation, odd, 1..255.

Ports:
- `clk_i`, in, 1: single clock. Bus and FSM run on the rising edge.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `wb_adr_i`, in, 32: address.
- `wb_dat_i`, in, 32: write data.
- `wb_dat_o`, out, 32: read data, registered.
- `wb_we_i`, in, 1: write enable.
- `wb_sel_i`, in, 4: byte enables.
- `wb_stb_i`, in, 1: strobe.
- `wb_cyc_i`, in, 1: cycle valid.
- `wb_ack_o`, out, 1: transfer acknowledge.
- `wb_err_o`, out, 1: transfer error.
- `puf_en_o`, out, 1: PUF enable.
- `puf_challenge_o`, out, `CHAL_WIDTH`: challenge held stable during an evaluation.
- `puf_id_i`, in, `ID_WIDTH`: raw PUF response, asynchronous; it is never synchronised, by design.
- `irq_o`, out, 1: level interrupt, equal to `DONE & IRQ_EN`, registered.

## Operation
Register map (word offset = `wb_adr_i[ADDR_WIDTH-1:2]`):
- 0 CTRL:
  - bit0 EN, rw.
  - bit1 START, write-1 pulse, reads 0.
  - bit2 BUSY, ro.
  - bit3 DONE, ro, cleared by writing 1 (w1c).
  - bit4 IRQ_EN, rw.
  - Only lane 0 (`wb_sel_i[0]`) affects CTRL.
- 1 CHALLENGE: rw, low `CHAL_WIDTH` bits; every byte lane honoured; unused bits read 0.
- 2 STATUS: ro.
  - [7:0] UNSTABLE: number of ID bits whose samples were not all equal, saturating at 255.
  - [15:8] `VOTE_SAMPLES`.
  - [23:16] `ID_WIDTH`.
  - [31:24] 0.
- 3 .. 2+`ID_WORDS`: ID word k at offset 3+k; unused upper bits of the last word read 0.
- Any other offset inside the window: `wb_err_o` instead of `wb_ack_o`; read data is 32'hBADFABAC; no register changes.
- Writes to ro registers: acked and ignored.
- Outside the window: no ack, no err.

FSM states:
- IDLE → SETTLE on an accepted START with EN=1 (or EN being set in the same write). The challenge register is copied to `puf_challenge_o`, the settle counter is loaded, per-bit vote counters are cleared, and DONE is cleared.
- SETTLE: `puf_en_o`=1; count down `SETTLE_CYCLES`; → SAMPLE.
- SAMPLE: `puf_en_o`=1; each cycle, add `puf_id_i[i]` to counter i (width clog2(`VOTE_SAMPLES`+1)); after `VOTE_SAMPLES` samples → RESOLVE.
- RESOLVE: ID bit i = (counter i > `VOTE_SAMPLES`/2); UNSTABLE updated; DONE set; `puf_en_o`=0; → IDLE.

Boundary rules:
- START while BUSY or with EN=0: ignored.
- CHALLENGE written while BUSY: register updates, but `puf_challenge_o` is unchanged until the next START.
- EN cleared while BUSY: abort to IDLE next edge; `puf_en_o`=0; ID, UNSTABLE and DONE unchanged.
- Same write sets DONE-clear and START: clear applies, then the evaluation starts.
- RESOLVE on the same edge as a DONE-clear write: the set wins.
- `rst_i` mid-evaluation: immediate return to IDLE with all reset values.

## Timing
- Reset values: `wb_ack_o`=0, `wb_err_o`=0, `wb_dat_o`=0, `puf_en_o`=0, `puf_challenge_o`=0, `irq_o`=0. CTRL, CHALLENGE, ID words and UNSTABLE all reset to 0.
- Bus handshake:
  - `wb_ack_o`/`wb_err_o` assert one edge after `wb_cyc_i & wb_stb_i` with an in-window address, and only if not already asserted. They stay high for exactly one cycle.
  - A held strobe yields one ack every 2 cycles.
  - Writes take effect on the edge that raises ack. Read data is valid in the ack cycle.
- Evaluation latency, counted from the START-accept edge T:
  - `puf_en_o` is high from T+1 for `SETTLE_CYCLES`+`VOTE_SAMPLES` cycles.
  - BUSY is 1 over the same span plus the RESOLVE cycle.
  - DONE and the new ID are visible from edge T+`SETTLE_CYCLES`+`VOTE_SAMPLES`+1.
  - `irq_o` follows one edge later.

## Structure
- Package `puf_ctrl_pkg` holds:
  - register offsets (CTRL, CHALLENGE, STATUS, ID0);
  - CTRL bit indices;
  - the FSM state enum (IDLE, SETTLE, SAMPLE, RESOLVE);
  - `DEFAULT_READ_VALUE` 32'hBADFABAC.
- Sub-module `puf_vote_accum` holds the per-bit sample counters, the majority output and the unstable-bit popcount (saturating), driven by clear/sample/resolve strobes from the FSM.

## Test plan
- Reset, then read CTRL, STATUS and ID0:
  - CTRL reads 0.
  - STATUS reads 0x00600500 for the defaults: [23:16]=0x60 (96), [15:8]=0x05, UNSTABLE=0.
  - ID0 reads 0.
  - Every transfer acks after exactly 1 cycle.
- Write CHALLENGE=0xA5A5_1234, then CTRL=0x03, with `puf_id_i` constant 0x..._DEADBEEF:
  - `puf_en_o` is high for 21 cycles.
  - DONE rises at T+22.
  - ID0 reads 0xDEADBEEF and UNSTABLE reads 0.
- Flip bit 0 of `puf_id_i` in 2 of 5 samples and bit 1 in 3 of 5 samples:
  - ID bit0=0, bit1=1.
  - UNSTABLE=2.
- Clear EN at SAMPLE cycle 2:
  - abort; `puf_en_o`=0 next cycle.
  - DONE stays 0; ID stays at the previous value.
- Read offset 6 and write offset 7:
  - `wb_err_o` pulses, no ack.
  - Read data is 0xBADFABAC; no register changes.
- Set IRQ_EN, complete an evaluation: `irq_o` rises 1 cycle after DONE. Then write 0x08 to CTRL (DONE w1c): `irq_o` drops on the next edge.
